interboard_link_tx: RTL and testbench
=====================================

Name: interboard_link_tx

Overview:
- Downstream of the game master FSM. Consumes its per-message handshake (`transmit`, `ctrl_en`, `ctrl_msg_type`, `ctrl_number`).
- Serializes each message as a UART-style frame onto one inter-board wire, then waits for the peer board's acknowledge.
- Returns `inter_ready` to the master once the peer has acknowledged.
- Retries on timeout. Raises a sticky error when retries are exhausted.

Parameters:
- BIT_CYCLES, 868: clk cycles per serial bit (115200 baud at 100 MHz); must be ≥2.
- ACK_TIMEOUT, 100000: clk cycles to wait in WAIT_ACK before a retry.
- MAX_RETRY, 3: number of resends after the first attempt before error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- transmit  in  1  master is in a sending state; qualifies ctrl_en
- ctrl_en  in  1  one-cycle request to send a message
- ctrl_msg_type  in  3  message type code (STATE_TURN/SEL_NUM/STATE_WIN…)
- ctrl_number  in  5  number payload (0–31)
- ack_in  in  1  acknowledge from peer board, asynchronous, rising-edge meaningful
- tx_line  out  1  serial line to peer; idles high
- inter_ready  out  1  one-cycle pulse when the peer has acknowledged the current message
- busy  out  1  high from message acceptance until DONE or ERROR
- link_err  out  1  sticky failure flag

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: tx_line=1, inter_ready=0, busy=0, link_err=0, state=IDLE; all counters and the payload register cleared.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_ACK, DONE, ERROR.
- IDLE → START when `ctrl_en && transmit`.
  - Same edge: latch payload = {ctrl_number, ctrl_msg_type}; retry_cnt=0; busy=1.
  - ctrl_en without transmit is ignored.
- Bit timing: START, DATA, PARITY and STOP each hold tx_line for exactly BIT_CYCLES cycles, counted by the baud counter.
  - START drives 0.
  - DATA sends 8 bits LSB first: type[0..2], then number[0..4].
  - PARITY drives the odd-parity bit, so the total count of 1s over 8 data bits + parity is odd.
  - STOP drives 1.
- First frame bit appears on tx_line the cycle after acceptance.
- Frame length: 11·BIT_CYCLES with parity, 10·BIT_CYCLES without.
- ack_in synchronization: 2-flop synchronizer, then a rising-edge detector.
  - Edges are honoured only in WAIT_ACK. Edges in any other state, including mid-frame, are discarded.
- WAIT_ACK: timeout counter counts from 0.
  - On a detected edge → DONE.
  - At count ACK_TIMEOUT−1 with retry_cnt<MAX_RETRY → START, retry_cnt+1, same latched payload.
  - At timeout with retry_cnt==MAX_RETRY → ERROR.
- DONE: lasts one cycle.
  - inter_ready=1 for exactly that cycle; busy drops in the same cycle.
  - Next state IDLE.
  - Latency: ack_in rise to inter_ready pulse is 3 clk cycles (2 sync + edge register).
- ERROR: tx_line=1, link_err=1, busy=0. No exit except rst.
- Requests while busy: ctrl_en ignored; no queueing; payload register unchanged.
- transmit falling mid-frame: does not abort; the frame and ack wait complete normally.
- Simultaneous ack edge and timeout in the same cycle: ack wins → DONE.
- rst mid-frame: tx_line returns high immediately (asynchronous); the peer discards the partial frame on its framing check.
- Counter widths: $clog2 of the respective parameter. No wrap-around occurs inside a bit period; the counter reloads at BIT_CYCLES−1.

Optional Feature:
- Macro: INTERBOARD_PARITY_EN.
- Defined: PARITY state present; frame = start + 8 data + odd parity + stop (11 bits).
- Undefined: PARITY state skipped, DATA → STOP directly; frame is 10 bits. The peer receiver must be built with the same setting.

Test Plan:
- Reset with BIT_CYCLES=4, ACK_TIMEOUT=64, MAX_RETRY=1: all outputs at reset values. Assert rst mid-DATA → tx_line=1 within the same cycle, busy=0.
- Parity on; ctrl_en+transmit with type=3'b010, number=5'd17: tx_line sequence, 4 cycles each, is 0 | 0,1,0,1,0,0,0,1 | 0 | 1. busy=1 for 44 cycles, then the FSM enters WAIT_ACK.
- Raise ack_in 10 cycles into WAIT_ACK → inter_ready high exactly 1 cycle, 3 cycles later; busy=0; state IDLE.
- No ack: after 64 WAIT_ACK cycles the identical frame is resent. After a second 64-cycle timeout → link_err=1 (sticky), and inter_ready never pulses.
- ctrl_en pulses mid-frame with a different payload, and ack_in pulses during DATA: both are ignored, the original frame completes, and WAIT_ACK still requires a new edge. A separate case with ctrl_en but transmit=0 in IDLE: no frame is sent.
- Parity off build: same payload as above → 40-cycle frame with no parity bit; ack handling is unchanged.

Source files
------------

// File: rtl/interboard_link_if.sv
// Handshake and line signals between the game master, interboard_link_tx and the peer board.
interface interboard_link_if;
    logic       transmit;
    logic       ctrl_en;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       ack_in;
    logic       tx_line;
    logic       inter_ready;
    logic       busy;
    logic       link_err;

    modport master (
        output transmit, ctrl_en, ctrl_msg_type, ctrl_number, ack_in,
        input  tx_line, inter_ready, busy, link_err
    );

    modport slave (
        input  transmit, ctrl_en, ctrl_msg_type, ctrl_number, ack_in,
        output tx_line, inter_ready, busy, link_err
    );
endinterface

// File: rtl/interboard_link_tx.sv
// UART-style message transmitter with peer acknowledge, timeout retry and sticky error.
// Optional odd parity bit enabled by defining INTERBOARD_PARITY_EN.
module interboard_link_tx #(
    parameter int BIT_CYCLES  = 868,
    parameter int ACK_TIMEOUT = 100000,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    interboard_link_if.slave  bus
);
    localparam int BW = $clog2(BIT_CYCLES);
    localparam int WW = $clog2(ACK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_ACK, ST_DONE, ST_ERROR
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    state_t        state_r, state_s;
    logic [BW-1:0] baud_r, baud_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [WW-1:0] wait_r, wait_s;
    logic [RW-1:0] retry_r, retry_s;
    logic [7:0]    payload_r, payload_s;
    logic          ack_sync1_r, ack_sync2_r, ack_prev_r;
    logic          tx_line_r, inter_ready_r, busy_r, link_err_r;
    logic          tx_s, busy_s, baud_end_s, ack_edge_s;

    assign baud_end_s = (baud_r == BAUD_LAST);
    assign ack_edge_s = ack_sync2_r & ~ack_prev_r;

    // Next-state logic: frame sequencing, ack wait, retry and error decisions.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        wait_s    = wait_r;
        retry_s   = retry_r;
        payload_s = payload_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.ctrl_en && bus.transmit) begin
                    state_s   = ST_START;
                    payload_s = {bus.ctrl_number, bus.ctrl_msg_type};
                    retry_s   = '0;
                    baud_s    = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_s   = ST_DATA;
                    baud_s    = '0;
                    bit_idx_s = 3'd0;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (bit_idx_r == 3'd7) begin
`ifdef INTERBOARD_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_s = ST_STOP;
                    baud_s  = '0;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    state_s = ST_WAIT_ACK;
                    baud_s  = '0;
                    wait_s  = '0;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            ST_WAIT_ACK: begin
                // An ack edge takes priority over an expiring timeout.
                if (ack_edge_s) begin
                    state_s = ST_DONE;
                end else if (wait_r == WAIT_LAST) begin
                    if (retry_r < RETRY_MAX) begin
                        state_s = ST_START;
                        retry_s = retry_r + RW'(1);
                        baud_s  = '0;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else begin
                    wait_s = wait_r + WW'(1);
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERROR: state_s = ST_ERROR;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output values for the upcoming state, so the registered line tracks the FSM without lag.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = payload_s[bit_idx_s];
            ST_PARITY: tx_s = odd_parity(payload_s);
            default:   tx_s = 1'b1;
        endcase
    end

    assign busy_s = (state_s == ST_START) || (state_s == ST_DATA) || (state_s == ST_PARITY) ||
                    (state_s == ST_STOP)  || (state_s == ST_WAIT_ACK);

    // State, counters, payload, ack synchronizer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            baud_r        <= '0;
            bit_idx_r     <= 3'd0;
            wait_r        <= '0;
            retry_r       <= '0;
            payload_r     <= 8'd0;
            ack_sync1_r   <= 1'b0;
            ack_sync2_r   <= 1'b0;
            ack_prev_r    <= 1'b0;
            tx_line_r     <= 1'b1;
            inter_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            link_err_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            baud_r        <= baud_s;
            bit_idx_r     <= bit_idx_s;
            wait_r        <= wait_s;
            retry_r       <= retry_s;
            payload_r     <= payload_s;
            ack_sync1_r   <= bus.ack_in;
            ack_sync2_r   <= ack_sync1_r;
            ack_prev_r    <= ack_sync2_r;
            tx_line_r     <= tx_s;
            inter_ready_r <= (state_s == ST_DONE);
            busy_r        <= busy_s;
            link_err_r    <= (state_s == ST_ERROR);
        end
    end

    assign bus.tx_line     = tx_line_r;
    assign bus.inter_ready = inter_ready_r;
    assign bus.busy        = busy_r;
    assign bus.link_err    = link_err_r;
endmodule

// File: tb/tb_interboard_link_tx.sv
// Self-checking bench for interboard_link_tx: vector table, corner sequences and randomized messages.
module tb_interboard_link_tx;
    localparam int BC = 4;
    localparam int TO = 64;
    localparam int MR = 1;
`ifdef INTERBOARD_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interboard_link_if bus();

    interboard_link_tx #(.BIT_CYCLES(BC), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [2:0] typ;
        logic [4:0] num;
        int         ack_k;
        logic [7:0] byt;
        logic       par;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input int t, input int n);
        return 8'(n * 8 + t);
    endfunction

    function automatic logic model_par(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    function automatic logic exp_bit(input int b, input logic [7:0] byt, input logic par);
        if (b == 0) return 1'b0;
        else if (b <= 8) return byt[b-1];
        else if (NB == 11 && b == 9) return par;
        else return 1'b1;
    endfunction

    task automatic start_msg(input logic [2:0] t, input logic [4:0] n);
        @(posedge clk); #1;
        bus.ctrl_msg_type = t;
        bus.ctrl_number   = n;
        bus.transmit      = 1'b1;
        bus.ctrl_en       = 1'b1;
    endtask

    // inject >= 0: at that frame cycle raise a competing request and an ack pulse, then drop transmit.
    task automatic check_frame(input logic [7:0] byt, input logic par, input int inject);
        int i;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < BC; c++) begin
                i = b * BC + c;
                @(posedge clk); #1;
                bus.ctrl_en = 1'b0;
                if (inject >= 0 && i == inject) begin
                    bus.ctrl_en       = 1'b1;
                    bus.ctrl_msg_type = 3'd5;
                    bus.ctrl_number   = 5'd9;
                    bus.ack_in        = 1'b1;
                end else if (inject >= 0 && i == inject + 6) begin
                    bus.ack_in = 1'b0;
                end else if (inject >= 0 && i == inject + 8) begin
                    bus.transmit = 1'b0;
                end
                chk("tx_bit", bus.tx_line, exp_bit(b, byt, par));
                chk("busy_frame", bus.busy, 1);
                chk("ready_frame", bus.inter_ready, 0);
            end
        end
    endtask

    task automatic wait_ack_cycles(input int k);
        for (int j = 0; j < k; j++) begin
            @(posedge clk); #1;
            chk("tx_wait", bus.tx_line, 1);
            chk("busy_wait", bus.busy, 1);
            chk("ready_wait", bus.inter_ready, 0);
        end
    endtask

    task automatic ack_and_check();
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        bus.ack_in = 1'b1;
        while (!found && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (bus.inter_ready === 1'b1) found = 1'b1;
        end
        chk("ready_latency", n, 3);
        chk("busy_done", bus.busy, 0);
        @(posedge clk); #1;
        chk("ready_width", bus.inter_ready, 0);
        chk("busy_idle", bus.busy, 0);
        bus.ack_in = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rt;
        logic [4:0] rn;
        logic [7:0] rb;
        int         rk;

        tbl[0] = '{3'd2, 5'd17, 10, 8'h8A, 1'b0};
        tbl[1] = '{3'd0, 5'd0,  1,  8'h00, 1'b1};
        tbl[2] = '{3'd7, 5'd31, 5,  8'hFF, 1'b1};
        tbl[3] = '{3'd5, 5'd10, 20, 8'h55, 1'b1};
        tbl[4] = '{3'd1, 5'd16, 62, 8'h81, 1'b1};
        tbl[5] = '{3'd3, 5'd1,  3,  8'h0B, 1'b0};
        tbl[6] = '{3'd4, 5'd7,  40, 8'h3C, 1'b1};

        bus.transmit = 1'b0; bus.ctrl_en = 1'b0; bus.ctrl_msg_type = 3'd0;
        bus.ctrl_number = 5'd0; bus.ack_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", bus.tx_line, 1);
        chk("rst_ready", bus.inter_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.link_err, 0);
        rst = 1'b0;

        foreach (tbl[v]) begin
            start_msg(tbl[v].typ, tbl[v].num);
            check_frame(tbl[v].byt, tbl[v].par, -1);
            wait_ack_cycles(tbl[v].ack_k);
            ack_and_check();
        end

        // Competing request, stray ack and transmit drop during DATA are all ignored.
        start_msg(3'd2, 5'd17);
        check_frame(8'h8A, 1'b0, 10);
        wait_ack_cycles(20);
        ack_and_check();

        // ctrl_en without transmit in IDLE sends nothing.
        @(posedge clk); #1;
        bus.transmit = 1'b0; bus.ctrl_en = 1'b1;
        bus.ctrl_msg_type = 3'd2; bus.ctrl_number = 5'd17;
        for (int j = 0; j < NB * BC + 4; j++) begin
            @(posedge clk); #1;
            bus.ctrl_en = 1'b0;
            chk("notx_line", bus.tx_line, 1);
            chk("notx_busy", bus.busy, 0);
        end

        for (int r = 0; r < 8; r++) begin
            rt = 3'($urandom_range(0, 7));
            rn = 5'($urandom_range(0, 31));
            rk = int'($urandom_range(1, 62));
            rb = model_byte(int'(rt), int'(rn));
            start_msg(rt, rn);
            check_frame(rb, model_par(rb), -1);
            wait_ack_cycles(rk);
            ack_and_check();
        end

        // Asynchronous reset in the middle of DATA.
        start_msg(3'd0, 5'd0);
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            bus.ctrl_en = 1'b0;
        end
        chk("pre_rst_tx", bus.tx_line, 0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_tx", bus.tx_line, 1);
        chk("midrst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // No ack: one resend of the identical frame, then sticky error.
        start_msg(3'd2, 5'd17);
        check_frame(8'h8A, 1'b0, -1);
        wait_ack_cycles(TO);
        check_frame(8'h8A, 1'b0, -1);
        wait_ack_cycles(TO);
        @(posedge clk); #1;
        chk("err_set", bus.link_err, 1);
        chk("err_busy", bus.busy, 0);
        chk("err_tx", bus.tx_line, 1);
        start_msg(3'd7, 5'd31);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            bus.ctrl_en = 1'b0;
            chk("err_sticky", bus.link_err, 1);
            chk("err_tx_hold", bus.tx_line, 1);
            chk("err_no_ready", bus.inter_ready, 0);
            chk("err_no_busy", bus.busy, 0);
        end
        rst = 1'b1;
        #1;
        chk("err_cleared", bus.link_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
